// File: rtl/uart_fifo_pkg.sv
// Shared constants and pointer helper for the UART synchronous FIFO.
// Pointers carry one extra wrap bit above the memory address bits.
package uart_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;

   typedef enum logic [1:0] {
      PTR_EMPTY   = 2'd0,
      PTR_FULL    = 2'd1,
      PTR_PARTIAL = 2'd2
   } ptr_rel_e;

   // Classify a write/read pointer pair. The pointers are zero-extended to
   // 32 bits and aw is the number of address bits, so bit aw is the wrap bit.
   function automatic ptr_rel_e ptr_compare(input logic [31:0] wp,
                                            input logic [31:0] rp,
                                            input int aw);
      logic [31:0] diff;
      logic [31:0] mask;
      diff = wp ^ rp;
      mask = (32'd1 << aw) - 32'd1;
      if ((diff & mask) != 32'd0)
         return PTR_PARTIAL;
      else if (((diff >> aw) & 32'd1) != 32'd0)
         return PTR_FULL;
      else
         return PTR_EMPTY;
   endfunction

endpackage

// File: rtl/uart_sync_fifo_if.sv
// Bus bundle between a FIFO user (master) and the FIFO itself (slave).
// Handshake: a write is taken on a rising edge where Wr_en=1 and either Full=0
// or a read is taken in the same cycle; a read is taken where Rd_en=1 and
// Empty=0. Requests that cannot be taken are dropped and reported through a
// one-cycle Overflow/Underflow pulse; there is no back-pressure stall.
interface uart_sync_fifo_if
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

   logic                  Wr_en;
   logic [DATA_WIDTH-1:0] Wr_data;
   logic                  Rd_en;
   logic [DATA_WIDTH-1:0] Rd_data;
   logic                  Rd_valid;
   logic                  Full;
   logic                  Empty;
   logic                  Almost_full;
   logic                  Almost_empty;
   logic [ADDR_WIDTH:0]   Count;
   logic                  Overflow;
   logic                  Underflow;

   modport master (
      output Wr_en, Wr_data, Rd_en,
      input  Rd_data, Rd_valid, Full, Empty, Almost_full, Almost_empty,
             Count, Overflow, Underflow
   );

   modport slave (
      input  Wr_en, Wr_data, Rd_en,
      output Rd_data, Rd_valid, Full, Empty, Almost_full, Almost_empty,
             Count, Overflow, Underflow
   );

endinterface

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART FIFO: synchronous write, asynchronous read,
// contents are never reset.
module uart_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  Clk,
   input  logic                  Wr_en,
   input  logic [ADDR_WIDTH-1:0] Wr_addr,
   input  logic [DATA_WIDTH-1:0] Wr_data,
   input  logic [ADDR_WIDTH-1:0] Rd_addr,
   output logic [DATA_WIDTH-1:0] Rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   // Store the write word at the write address on the clock edge.
   always_ff @(posedge Clk) begin
      if (Wr_en)
         mem[Wr_addr] <= Wr_data;
   end

   assign Rd_data = mem[Rd_addr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered status flags and error pulses.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads; the default
// build presents a popped word one cycle after the accepted read.
module uart_sync_fifo
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_TH  = 2
) (
   input logic             Clk,
   input logic             Reset,
   uart_sync_fifo_if.slave bus
);

   localparam int            PW  = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [PW-1:0]         count_q, count_nxt;
   logic                  wr_acc, rd_acc;
   logic                  full_q, empty_q, afull_q, aempty_q;
   logic                  ovf_q, udf_q;
   ptr_rel_e              rel_nxt;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Accept decisions, next pointers and next count from current state.
   always_comb begin
      rd_acc     = bus.Rd_en && !empty_q;
      wr_acc     = bus.Wr_en && (!full_q || rd_acc);
      wr_ptr_nxt = wr_acc ? wr_ptr + ONE : wr_ptr;
      rd_ptr_nxt = rd_acc ? rd_ptr + ONE : rd_ptr;
      count_nxt  = count_q;
      if (wr_acc && !rd_acc)
         count_nxt = count_q + ONE;
      else if (rd_acc && !wr_acc)
         count_nxt = count_q - ONE;
      rel_nxt = ptr_compare(32'(wr_ptr_nxt), 32'(rd_ptr_nxt), ADDR_WIDTH);
   end

   // Pointers, count and flags all register the post-edge state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         count_q  <= count_nxt;
         full_q   <= (rel_nxt == PTR_FULL);
         empty_q  <= (rel_nxt == PTR_EMPTY);
         afull_q  <= (int'(count_nxt) >= AFULL_TH);
         aempty_q <= (int'(count_nxt) <= AEMPTY_TH);
         ovf_q    <= bus.Wr_en && !wr_acc;
         udf_q    <= bus.Rd_en && empty_q;
      end
   end

   uart_fifo_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem (
      .Clk     (Clk),
      .Wr_en   (wr_acc),
      .Wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .Wr_data (bus.Wr_data),
      .Rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
      .Rd_data (mem_rdata)
   );

`ifdef UART_FIFO_FWFT_EN
   // Head word is always visible; Rd_en only acknowledges it.
   assign bus.Rd_data  = mem_rdata;
   assign bus.Rd_valid = !empty_q;
`else
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;

   // Capture the popped word; hold it until the next accepted read.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc)
            rd_data_q <= mem_rdata;
      end
   end

   assign bus.Rd_data  = rd_data_q;
   assign bus.Rd_valid = rd_valid_q;
`endif

   assign bus.Full         = full_q;
   assign bus.Empty        = empty_q;
   assign bus.Almost_full  = afull_q;
   assign bus.Almost_empty = aempty_q;
   assign bus.Count        = count_q;
   assign bus.Overflow     = ovf_q;
   assign bus.Underflow    = udf_q;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Bench for uart_sync_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
// Define UART_FIFO_FWFT_EN to check the first-word-fall-through build.
module tb_uart_sync_fifo;

   localparam int DW        = 8;
   localparam int AW        = 4;
   localparam int DEPTH     = 16;
   localparam int AFULL_TH  = 14;
   localparam int AEMPTY_TH = 2;

   // ---------------- clock / reset ----------------
   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   always #5 Clk = ~Clk;

   uart_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f_if ();

   uart_sync_fifo #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .AFULL_TH   (AFULL_TH),
      .AEMPTY_TH  (AEMPTY_TH)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (f_if)
   );

   // ---------------- scoreboard state ----------------
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_rd_data;
   logic          exp_rd_valid;
   logic          exp_ovf;
   logic          exp_udf;
   int            n_total = 0;
   int            n_pass  = 0;
   int            cyc     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Compare every output against the model's view of the FIFO.
   task automatic check_outputs();
      int sz;
      sz = exp_q.size();
      check("count",     32'(f_if.Count),        32'(sz));
      check("full",      32'(f_if.Full),         32'(sz == DEPTH));
      check("empty",     32'(f_if.Empty),        32'(sz == 0));
      check("afull",     32'(f_if.Almost_full),  32'(sz >= AFULL_TH));
      check("aempty",    32'(f_if.Almost_empty), 32'(sz <= AEMPTY_TH));
      check("overflow",  32'(f_if.Overflow),     32'(exp_ovf));
      check("underflow", 32'(f_if.Underflow),    32'(exp_udf));
`ifdef UART_FIFO_FWFT_EN
      check("rd_valid",  32'(f_if.Rd_valid),     32'(sz > 0));
      if (sz > 0)
         check("rd_data_head", 32'(f_if.Rd_data), 32'(exp_q[0]));
`else
      check("rd_valid",  32'(f_if.Rd_valid),     32'(exp_rd_valid));
      check("rd_data",   32'(f_if.Rd_data),      32'(exp_rd_data));
`endif
   endtask

   // ---------------- driver ----------------
   // Drive one cycle of requests, advance the model by the FIFO rules, check.
   task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd);
      int   sz;
      logic rd_ok, wr_ok;
      f_if.Wr_en   = wr;
      f_if.Wr_data = d;
      f_if.Rd_en   = rd;
      sz    = exp_q.size();
      rd_ok = rd && (sz > 0);
      wr_ok = wr && ((sz < DEPTH) || rd_ok);
      @(posedge Clk);
      #1;
      cyc++;
      exp_ovf      = wr && !wr_ok;
      exp_udf      = rd && (sz == 0);
      exp_rd_valid = rd_ok;
      if (rd_ok) exp_rd_data = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
      f_if.Wr_en = 1'b0;
      f_if.Rd_en = 1'b0;
      check_outputs();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      cyc++;
      exp_q.delete();
      exp_rd_data  = '0;
      exp_rd_valid = 1'b0;
      exp_ovf      = 1'b0;
      exp_udf      = 1'b0;
      check_outputs();
      Reset = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $fatal(1, "FAIL watchdog: simulation did not finish in time");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int written;
      int lvl;
      f_if.Wr_en   = 1'b0;
      f_if.Wr_data = '0;
      f_if.Rd_en   = 1'b0;
      exp_rd_data  = '0;
      exp_rd_valid = 1'b0;
      exp_ovf      = 1'b0;
      exp_udf      = 1'b0;

      // Reset state.
      repeat (2) @(posedge Clk);
      #1;
      check_outputs();
      Reset = 1'b0;

      // Reset mid-fill with five words discards them.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 8'h30), 1'b0);
      do_reset();
      check("reset_midfill_count", 32'(f_if.Count), 32'd0);

      // Fill 0x01..0x10, watching the almost-full edge at 13 -> 14.
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, 8'(i), 1'b0);
         if (i == 13) check("afull_at_13", 32'(f_if.Almost_full), 32'd0);
         if (i == 14) check("afull_at_14", 32'(f_if.Almost_full), 32'd1);
      end
      check("fill_full", 32'(f_if.Full), 32'd1);

      // Write while full: one-cycle overflow pulse, count stays 16.
      step(1'b1, 8'hAA, 1'b0);
      check("ovf_pulse", 32'(f_if.Overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0);
      check("ovf_cleared", 32'(f_if.Overflow), 32'd0);

      // Drain 16 in order; almost-empty appears at 3 -> 2.
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b0, 8'h00, 1'b1);
         if (exp_q.size() == 3) check("aempty_at_3", 32'(f_if.Almost_empty), 32'd0);
         if (exp_q.size() == 2) check("aempty_at_2", 32'(f_if.Almost_empty), 32'd1);
      end

      // Read while empty: underflow pulse.
      step(1'b0, 8'h00, 1'b1);
      check("udf_pulse", 32'(f_if.Underflow), 32'd1);
      step(1'b0, 8'h00, 1'b0);

      // Full plus simultaneous read and write: both taken, still full.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      step(1'b1, 8'h5A, 1'b1);
      check("simul_full_stays", 32'(f_if.Full), 32'd1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);

      // Empty plus simultaneous read and write: write only, underflow.
      step(1'b1, 8'h77, 1'b1);
      check("simul_empty_count", 32'(f_if.Count), 32'd1);
      step(1'b0, 8'h00, 1'b1);

      // Wrap: 40 write/read pairs with the level oscillating 0..3.
      written = 0;
      lvl     = 0;
      while (written < 40) begin
         while (lvl < 3 && written < 40) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            lvl++;
            written++;
         end
         while (lvl > 0) begin
            step(1'b0, 8'h00, 1'b1);
            lvl--;
         end
      end

      // Randomized traffic, alternating write-heavy and read-heavy phases.
      for (int ph = 0; ph < 8; ph++) begin
         for (int c = 0; c < 40; c++) begin
            int pw;
            pw = ph[0] ? 25 : 75;
            step(($urandom_range(0, 99) < pw), 8'($urandom),
                 ($urandom_range(0, 99) >= pw));
         end
      end

      // Reset in the middle of traffic, then confirm the FIFO works again.
      for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_sync_fifo.md
UART_SYNC_FIFO -- requirements
Module: uart_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, log2 of depth (DEPTH = 2**ADDR_WIDTH).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, Almost_full asserted when Count >= AFULL_TH.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, Almost_empty asserted when Count <= AEMPTY_TH.
REQ-005 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port Wr_en  input  1  write request.
REQ-008 SHALL have port Wr_data  input  DATA_WIDTH  write word.
REQ-009 SHALL have port Rd_en  input  1  read request / pop.
REQ-010 SHALL have port Rd_data  output  DATA_WIDTH  read word.
REQ-011 SHALL have port Rd_valid  output  1  Rd_data holds a popped word.
REQ-012 SHALL have port Full, Empty, Almost_full, Almost_empty  output  1 each  status flags.
REQ-013 SHALL have port Count  output  ADDR_WIDTH+1  stored words, 0..DEPTH.
REQ-014 SHALL have port Overflow, Underflow  output  1 each  one-cycle error pulses.

Function
REQ-015 SHALL use ADDR_WIDTH+1-bit write/read pointers; low bits address memory, MSB is wrap bit; natural wrap DEPTH-1 -> 0.
REQ-016 SHALL flag Empty when pointers fully equal, Full when addresses equal and wrap bits differ.
REQ-017 SHALL accept a write when Wr_en && (!Full || accepted read in same cycle); word stored at write address, write pointer +1.
REQ-018 SHALL accept a read when Rd_en && !Empty; read pointer +1; write in the same cycle on empty is stored but not returned this cycle.
REQ-019 SHALL update Count +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-020 SHALL register all flags and Count so they reflect the post-edge state in the cycle after the edge.
REQ-021 SHALL pulse Overflow for one cycle after Wr_en rejected (Full, no accepted read); contents and pointers unchanged.
REQ-022 SHALL pulse Underflow for one cycle after Rd_en while Empty; pointers unchanged.
REQ-023 SHALL (non-FWFT) present the popped word on Rd_data with Rd_valid=1 one cycle after the accepted read; Rd_data holds last value otherwise, Rd_valid=0.

Reset
REQ-024 SHALL on Reset clear pointers, Count=0, Empty=1, Almost_empty=1, Full=0, Almost_full=0, Overflow=0, Underflow=0, Rd_valid=0, Rd_data=0.
REQ-025 SHALL not reset memory contents; reset mid-operation discards all stored words.

Configuration
REQ-026 SHALL compile first-word-fall-through mode when macro UART_FIFO_FWFT_EN is defined.
REQ-027 SHALL with UART_FIFO_FWFT_EN drive Rd_data combinationally from head word, Rd_valid = !Empty, Rd_en acts as pop acknowledge; Rd_data undefined-but-stable when Empty.
REQ-028 SHALL without UART_FIFO_FWFT_EN behave per REQ-023.

Structure
REQ-029 SHALL place default DATA_WIDTH/ADDR_WIDTH constants and a pointer-compare helper in shared package uart_fifo_pkg.
REQ-030 SHALL instantiate one sub-module uart_fifo_mem: parametrised dual-port array, synchronous write, asynchronous read, no reset.

Verification
REQ-031 SHALL cover reset: assert Reset mid-fill with 5 words -> next cycle Count=0, Empty=1, Rd_valid=0.
REQ-032 SHALL cover fill/drain (ADDR_WIDTH=4): write 0x01..0x10 -> Full=1, Count=16; read 16 -> data 0x01..0x10 in order, Empty=1.
REQ-033 SHALL cover overflow/underflow: write 0xAA while Full -> Overflow pulse 1 cycle, Count stays 16; Rd_en while Empty -> Underflow pulse, Count 0.
REQ-034 SHALL cover simultaneous: Full plus Wr_en and Rd_en -> both accepted, Count stays 16, Full stays 1; Empty plus both -> write only, Underflow pulse, Count=1.
REQ-035 SHALL cover wrap: 40 write/read pairs with Count oscillating 0..3 -> all data matches, pointers wrap twice.
REQ-036 SHALL cover thresholds and modes: Count 13->14 asserts Almost_full, 3->2 asserts Almost_empty; run REQ-032 with and without UART_FIFO_FWFT_EN (FWFT: Rd_data=0x01 before first Rd_en).
